// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry, types and helpers for the sprite row reader
package sprite_pkg;

    localparam int SPR_W = 40;
    localparam int SPR_H = 40;
    localparam int IDX_W = 8;
    localparam int COL_W = 6;

    localparam logic [IDX_W-1:0] TRANSPARENT = 8'd0;

    typedef logic [IDX_W-1:0] sprite_idx_t;
    typedef sprite_idx_t [0:SPR_H-1][0:SPR_W-1] sprite_arr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SWAP  = 2'd2
    } fetch_state_t;

    // Unsigned 6-bit bound check used for both row and column limits.
    function automatic logic in_range(input logic [COL_W-1:0] v, input int lim);
        return v < COL_W'(lim);
    endfunction

endpackage

// File: rtl/sprite_row_reader_if.sv
// rtl/sprite_row_reader_if.sv - fetch and pixel-read handshake bundle of the sprite row reader
//
// master : fetch/read requester (colour mapper side)
// slave  : sprite_row_reader
// fetch_req/fetch_row -> request a row copy; busy/fetch_done/fetch_err <- status
// rd_en/rd_col        -> pixel read;        rd_data/rd_valid/rd_opaque <- registered result
interface sprite_row_reader_if;
    import sprite_pkg::*;

    logic              fetch_req;
    logic [COL_W-1:0]  fetch_row;
    logic              busy;
    logic              fetch_done;
    logic              fetch_err;
    logic              rd_en;
    logic [COL_W-1:0]  rd_col;
    sprite_idx_t       rd_data;
    logic              rd_valid;
    logic              rd_opaque;

    modport master (
        output fetch_req, fetch_row, rd_en, rd_col,
        input  busy, fetch_done, fetch_err, rd_data, rd_valid, rd_opaque
    );

    modport slave (
        input  fetch_req, fetch_row, rd_en, rd_col,
        output busy, fetch_done, fetch_err, rd_data, rd_valid, rd_opaque
    );

endinterface

// File: rtl/sprite_line_buf.sv
// rtl/sprite_line_buf.sv - one SPR_W-entry palette-index line buffer, one write port, one registered read port
//
// clk, reset : clock, synchronous active-high reset (clears every entry to TRANSPARENT)
// we/waddr/wdata : write port, out-of-range addresses are dropped
// re/raddr/rdata : registered read port, rdata holds when re=0 or raddr is out of range
module sprite_line_buf
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [COL_W-1:0] waddr,
    input  sprite_idx_t      wdata,
    input  logic             re,
    input  logic [COL_W-1:0] raddr,
    output sprite_idx_t      rdata
);

    sprite_idx_t mem [0:SPR_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SPR_W; i++) begin
                mem[i] <= TRANSPARENT;
            end
            rdata <= TRANSPARENT;
        end else begin
            if (we && in_range(waddr, SPR_W)) begin
                mem[waddr] <= wdata;
            end
            if (re && in_range(raddr, SPR_W)) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sprite_row_reader.sv
// rtl/sprite_row_reader.sv - copies one sprite row into a ping-pong line buffer and serves registered pixel reads
//
// Clk   : system clock
// Reset : synchronous active-high reset; aborts any fetch, clears both buffers
// index : combinational sprite index array from the ROM
// bus   : fetch request/status and pixel read channel (slave side)
module sprite_row_reader
    import sprite_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  sprite_arr_t index,
    sprite_row_reader_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_FETCH = 2'(FETCH);
    localparam logic [1:0] ST_SWAP  = 2'(SWAP);

    logic [1:0]       state;
    logic [COL_W-1:0] cnt;
    logic [COL_W-1:0] row;
    logic             front_sel;
    logic             fetch_err_q;
    logic             rd_valid_q;
    logic             rd_sel_q;
    logic             rd_ok_q;

    logic             fetching;
    logic             col_ok;
    logic             rd_fire;
    sprite_idx_t      wdata;
    sprite_idx_t      rdata0;
    sprite_idx_t      rdata1;
    sprite_idx_t      rd_mux;

    assign fetching = (state == ST_FETCH);
    assign col_ok   = in_range(bus.rd_col, SPR_W);
    assign rd_fire  = bus.rd_en && col_ok;
    assign wdata    = index[row][cnt];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            row         <= '0;
            front_sel   <= 1'b0;
            fetch_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            fetch_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.fetch_req) begin
                        if (in_range(bus.fetch_row, SPR_H)) begin
                            row   <= bus.fetch_row;
                            cnt   <= '0;
                            state <= ST_FETCH;
                        end else begin
                            fetch_err_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // Final element is written this cycle; counter parks at 0.
                    if (cnt == COL_W'(SPR_W - 1)) begin
                        cnt   <= '0;
                        state <= ST_SWAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SWAP: begin
                    // Select flips at the end of SWAP so a read sampled during
                    // SWAP still sees the old front buffer.
                    front_sel <= ~front_sel;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            rd_valid_q <= bus.rd_en;
            // The buffer choice and range result are captured with the read so
            // rd_data stays stable across later swaps until the next read.
            if (bus.rd_en) begin
                rd_sel_q <= front_sel;
                rd_ok_q  <= col_ok;
            end
        end
    end

    // Buffer 0 is the back buffer while front_sel=1, and vice versa.
    sprite_line_buf u_buf0 (
        .clk   (Clk),
        .reset (Reset),
        .we    (fetching && front_sel),
        .waddr (cnt),
        .wdata (wdata),
        .re    (rd_fire),
        .raddr (bus.rd_col),
        .rdata (rdata0)
    );

    sprite_line_buf u_buf1 (
        .clk   (Clk),
        .reset (Reset),
        .we    (fetching && !front_sel),
        .waddr (cnt),
        .wdata (wdata),
        .re    (rd_fire),
        .raddr (bus.rd_col),
        .rdata (rdata1)
    );

    assign rd_mux         = rd_sel_q ? rdata1 : rdata0;
    assign bus.rd_data    = rd_ok_q ? rd_mux : TRANSPARENT;
    assign bus.rd_opaque  = rd_ok_q && (rd_mux != TRANSPARENT);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = fetching;
    assign bus.fetch_done = (state == ST_SWAP);
    assign bus.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_sprite_row_reader.sv
// tb/tb_sprite_row_reader.sv - self-checking bench for sprite_row_reader
module tb_sprite_row_reader;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    sprite_arr_t rom;

    sprite_row_reader_if bus();

    sprite_row_reader dut (
        .Clk   (Clk),
        .Reset (Reset),
        .index (rom),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    int          front_row = -1;    // row currently visible to reads, -1 = all transparent
    sprite_idx_t last_data = TRANSPARENT;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic sprite_idx_t model_px(input int fr, input int col);
        if (fr < 0 || col >= SPR_W) return TRANSPARENT;
        return rom[fr][col];
    endfunction

    task automatic do_read(input int col);
        sprite_idx_t exp;
        bus.rd_en  = 1'b1;
        bus.rd_col = 6'(col);
        step();
        bus.rd_en = 1'b0;
        exp = model_px(front_row, col);
        chk($sformatf("rd_valid col%0d", col), 32'(bus.rd_valid), 32'd1);
        chk($sformatf("rd_data col%0d", col), 32'(bus.rd_data), 32'(exp));
        chk($sformatf("rd_opaque col%0d", col), 32'(bus.rd_opaque),
            32'((col < SPR_W) && (exp != TRANSPARENT)));
        last_data = exp;
    endtask

    task automatic read_hold();
        bus.rd_en  = 1'b0;
        bus.rd_col = 6'($urandom_range(0, 39));
        step();
        chk("hold rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("hold rd_data", 32'(bus.rd_data), 32'(last_data));
    endtask

    task automatic do_err(input int r);
        bus.fetch_req = 1'b1;
        bus.fetch_row = 6'(r);
        step();
        bus.fetch_req = 1'b0;
        chk($sformatf("fetch_err row%0d", r), 32'(bus.fetch_err), 32'd1);
        chk("err no busy", 32'(bus.busy), 32'd0);
        step();
        chk("fetch_err one pulse", 32'(bus.fetch_err), 32'd0);
        chk("err still idle", 32'(bus.busy), 32'd0);
    endtask

    // swap_col >= 0 issues a read in the SWAP cycle and again the cycle after.
    // poke raises a second fetch_req while busy; it must be ignored.
    task automatic do_fetch(input int r, input int swap_col, input bit poke);
        int done_at = 0;
        int busy_cnt = 0;
        int extra_done = 0;
        int old_row;
        bus.fetch_req = 1'b1;
        bus.fetch_row = 6'(r);
        step();
        bus.fetch_req = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (poke && n == 5) begin
                bus.fetch_req = 1'b1;
                bus.fetch_row = 6'((r + 7) % SPR_H);
            end else begin
                bus.fetch_req = 1'b0;
            end
            if (bus.fetch_done) begin
                done_at = n;
                break;
            end
            if (bus.busy) busy_cnt++;
            step();
        end
        bus.fetch_req = 1'b0;
        chk($sformatf("done latency row%0d", r), done_at, SPR_W + 1);
        chk($sformatf("busy cycles row%0d", r), busy_cnt, SPR_W);
        old_row = front_row;
        if (swap_col >= 0) begin
            bus.rd_en  = 1'b1;
            bus.rd_col = 6'(swap_col);
            step();
            chk("swap read old front", 32'(bus.rd_data), 32'(model_px(old_row, swap_col)));
            chk("done single pulse", 32'(bus.fetch_done), 32'd0);
            front_row = r;
            step();
            bus.rd_en = 1'b0;
            chk("post swap read new row", 32'(bus.rd_data), 32'(model_px(r, swap_col)));
            last_data = model_px(r, swap_col);
        end else begin
            front_row = r;
            step();
            chk("done single pulse", 32'(bus.fetch_done), 32'd0);
        end
        if (poke) begin
            for (int n = 0; n < 50; n++) begin
                if (bus.fetch_done || bus.busy) extra_done++;
                step();
            end
            chk("poke ignored", extra_done, 0);
        end
    endtask

    initial begin
        int done_seen;
        bus.fetch_req = 1'b0;
        bus.fetch_row = '0;
        bus.rd_en     = 1'b0;
        bus.rd_col    = '0;
        for (int r = 0; r < SPR_H; r++) begin
            for (int c = 0; c < SPR_W; c++) begin
                rom[r][c] = sprite_idx_t'($urandom_range(0, 255));
            end
        end
        rom[0][0]   = 8'd13;
        rom[0][1]   = 8'd12;
        rom[13][14] = 8'd14;
        rom[13][26] = 8'd12;
        rom[13][27] = 8'd16;
        rom[39][1]  = 8'd13;

        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset fetch_done", 32'(bus.fetch_done), 32'd0);
        chk("reset fetch_err", 32'(bus.fetch_err), 32'd0);
        chk("reset rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset rd_data", 32'(bus.rd_data), 32'(TRANSPARENT));
        chk("reset rd_opaque", 32'(bus.rd_opaque), 32'd0);
        do_read(5);
        chk("idle busy", 32'(bus.busy), 32'd0);

        do_fetch(0, -1, 1'b0);
        do_read(0);
        do_read(1);

        do_fetch(13, -1, 1'b0);
        do_read(14);
        do_read(26);
        do_read(27);
        do_read(40);
        do_read(27);
        read_hold();

        do_fetch(0, -1, 1'b0);
        do_fetch(39, 1, 1'b0);

        do_err(45);
        do_read(1);
        do_err($urandom_range(40, 63));
        do_read(0);

        do_fetch(5, -1, 1'b1);
        do_read(3);

        repeat (6) begin
            do_fetch($urandom_range(0, SPR_H - 1), -1, 1'b0);
            repeat (4) do_read($urandom_range(0, 63));
            read_hold();
        end

        // Reset on FETCH cycle 20.
        bus.fetch_req = 1'b1;
        bus.fetch_row = 6'd7;
        step();
        bus.fetch_req = 1'b0;
        repeat (19) step();
        chk("busy before abort", 32'(bus.busy), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        front_row = -1;
        done_seen = 0;
        for (int n = 0; n < 50; n++) begin
            if (bus.fetch_done) done_seen++;
            step();
        end
        chk("abort no done", done_seen, 0);
        do_read(0);
        do_read(1);
        do_read(39);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
